// File: rtl/bridge_pkg.sv
// Shared constants, state encoding and hex decode for the UART command parser.
package bridge_pkg;

  localparam int unsigned BUS_W = 16;

  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_W  = 8'h57;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    READ_ADDR,
    READ_TERM,
    WRITE_ADDR,
    WRITE_DATA,
    WRITE_TERM,
    ERROR
  } state_e;

  // Returns {is_hex, nibble}; letters share the low-nibble offset in both cases.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/bridge_rx.sv
// ASCII command parser: 'R' AAAA <term> and 'W' AAAA DDDD <term> into 16-bit bus strobes.
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic [BUS_W-1:0] addr_o,
  output logic [BUS_W-1:0] wdata_o,
  output logic [BUS_W-1:0] rdata_o,
  output logic             rw_o,
  output logic             valid_o,
  output logic             error_o
);

  state_e           state;
  logic [1:0]       dcnt;
  logic [BUS_W-1:0] addr_sr;
  logic [BUS_W-1:0] data_sr;
  logic [31:0]      tcnt;

  logic [4:0] hx;
  logic       is_term;
  logic       in_cmd;
  logic       timed_out;

  assign rdata_o   = '0;
  assign hx        = hex_to_nibble(data_i);
  assign is_term   = (data_i == CHAR_CR) || (data_i == CHAR_LF);
  assign in_cmd    = (state != IDLE) && (state != ERROR);
  assign timed_out = (TIMEOUT_CYCLES != 0) && in_cmd && !valid_i &&
                     (tcnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dcnt    <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      tcnt    <= '0;
      addr_o  <= '0;
      wdata_o <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      error_o <= 1'b0;

      if (!in_cmd || valid_i) begin
        tcnt <= '0;
      end else if (TIMEOUT_CYCLES != 0) begin
        tcnt <= tcnt + 32'd1;
      end

      if (timed_out) begin
        state   <= ERROR;
        error_o <= 1'b1;
        tcnt    <= '0;
      end else if (valid_i) begin
        unique case (state)
          // ERROR lasts one cycle and handles a same-cycle byte exactly like IDLE.
          IDLE, ERROR: begin
            dcnt    <= '0;
            addr_sr <= '0;
            data_sr <= '0;
            if (data_i == CHAR_R) begin
              state <= READ_ADDR;
            end else if (data_i == CHAR_W) begin
              state <= WRITE_ADDR;
            end else begin
              state   <= IDLE;
              error_o <= !is_term;
            end
          end
          READ_ADDR, WRITE_ADDR, WRITE_DATA: begin
            if (hx[4]) begin
              if (state == WRITE_DATA) begin
                data_sr <= {data_sr[BUS_W-5:0], hx[3:0]};
              end else begin
                addr_sr <= {addr_sr[BUS_W-5:0], hx[3:0]};
              end
              dcnt <= dcnt + 2'd1;
              if (dcnt == 2'd3) begin
                if (state == READ_ADDR) begin
                  state <= READ_TERM;
                end else if (state == WRITE_ADDR) begin
                  state <= WRITE_DATA;
                end else begin
                  state <= WRITE_TERM;
                end
              end
            end else begin
              state   <= ERROR;
              error_o <= 1'b1;
            end
          end
          READ_TERM, WRITE_TERM: begin
            if (is_term) begin
              valid_o <= 1'b1;
              addr_o  <= addr_sr;
              wdata_o <= (state == WRITE_TERM) ? data_sr : '0;
              rw_o    <= (state == WRITE_TERM);
              state   <= IDLE;
            end else begin
              state   <= ERROR;
              error_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == ERROR) begin
        state <= IDLE;
      end
    end
  end

endmodule
